m6502_bus_initiator: RTL and testbench

//  6502-style bus initiator: the master end of the bus served by the RRIOT responder.

---
 rtl/m6502_bus_initiator.sv | 207 ++++++++++++++++++++
 tb/tb_m6502_bus_initiator.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m6502_bus_initiator.sv
// 6502-style bus initiator: queues read/write commands and runs one registered bus cycle each.
// Optional wait-for-IRQ command support is enabled by defining M6502_BUS_INIT_IRQ_WAIT_EN.
module m6502_bus_initiator #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic              phi2,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic              cmd_rs0,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] A_o,
   output logic              RS0_o,
   output logic              R_W_o,
   output logic              CS1_o,
   output logic [7:0]        DB_o,
   output logic              DB_oe,
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   input  logic              cmd_wait_irq,
   input  logic              IRQ_n_i,
`endif
   input  logic [7:0]        DB_i
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   localparam int unsigned ENT_W = ADDR_W + 11;
`else
   localparam int unsigned ENT_W = ADDR_W + 10;
`endif
   // The issue cycle counts as the first latency cycle and CAPT as the last.
   localparam logic [2:0] WAIT_LOAD = (RD_LATENCY > 2) ? 3'(RD_LATENCY - 2) : 3'd1;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StIssue = 3'd1;
   localparam logic [2:0] StWait  = 3'd2;
   localparam logic [2:0] StCapt  = 3'd3;
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   localparam logic [2:0] StWirq  = 3'd4;
`endif

   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              full, empty, push, pop, launch;
   logic [ENT_W-1:0]  head;

   logic [2:0]        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic              rs0_q, rs0_d, rw_q, rw_d, cs1_q, cs1_d, oe_q, oe_d;
   logic [7:0]        dbo_q, dbo_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [7:0]        rsp_rdata_q, rsp_rdata_d;
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   logic [1:0]        irq_sync_q;
`endif

   assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr_q];

   always_ff @(posedge phi2) begin
      if (push) begin
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
         mem[wr_ptr_q] <= {cmd_wait_irq, cmd_we, cmd_rs0, cmd_addr, cmd_wdata};
`else
         mem[wr_ptr_q] <= {cmd_we, cmd_rs0, cmd_addr, cmd_wdata};
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      launch      = 1'b0;
      pop         = 1'b0;
      a_d         = '0;
      rs0_d       = 1'b0;
      rw_d        = 1'b1;
      cs1_d       = 1'b0;
      dbo_d       = '0;
      oe_d        = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         StIdle: launch = 1'b1;
         StIssue: begin
            if (!rw_q) begin
               launch = 1'b1;
            end else if (RD_LATENCY == 1) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = DB_i;
               launch      = 1'b1;
            end else if (RD_LATENCY == 2) begin
               state_d = StCapt;
            end else begin
               state_d = StWait;
               cnt_d   = WAIT_LOAD;
            end
         end
         StWait: begin
            if (cnt_q <= 3'd1) state_d = StCapt;
            else               cnt_d   = cnt_q - 3'd1;
         end
         StCapt: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = DB_i;
            launch      = 1'b1;
         end
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
         StWirq: begin
            if (!irq_sync_q[1]) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 8'h80;
               launch      = 1'b1;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      // Start the next queued command without a dead cycle, or fall back to idle.
      if (launch) begin
         if (!empty) begin
            pop = 1'b1;
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
            if (head[ADDR_W+10]) state_d = StWirq;
            else
`endif
            begin
               state_d = StIssue;
               a_d     = head[ADDR_W+7:8];
               rs0_d   = head[ADDR_W+8];
               rw_d    = !head[ADDR_W+9];
               cs1_d   = 1'b1;
               oe_d    = head[ADDR_W+9];
               dbo_d   = head[ADDR_W+9] ? head[7:0] : 8'h00;
            end
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         a_q         <= '0;
         rs0_q       <= 1'b0;
         rw_q        <= 1'b1;
         cs1_q       <= 1'b0;
         dbo_q       <= '0;
         oe_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         rs0_q       <= rs0_d;
         rw_q        <= rw_d;
         cs1_q       <= cs1_d;
         dbo_q       <= dbo_d;
         oe_q        <= oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   always_ff @(posedge phi2 or negedge rst_n) begin
      if (!rst_n) irq_sync_q <= 2'b11;
      else        irq_sync_q <= {irq_sync_q[0], IRQ_n_i};
   end
`endif

   assign A_o       = a_q;
   assign RS0_o     = rs0_q;
   assign R_W_o     = rw_q;
   assign CS1_o     = cs1_q;
   assign DB_o      = dbo_q;
   assign DB_oe     = oe_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_m6502_bus_initiator.sv
// Bench for m6502_bus_initiator: directed and random commands checked against a
// transaction-level timing model (issue cycle = max(push edge + 1, previous completion)).
module tb_m6502_bus_initiator;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LAT    = 2;
   localparam int          MAXC   = 512;

   logic              phi2 = 1'b0;
   logic              rst_n = 1'b0;
   logic              cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0, cmd_rs0 = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [7:0]        cmd_wdata = '0, rsp_rdata, DB_o, DB_i = '0;
   logic              rsp_valid, busy, RS0_o, R_W_o, CS1_o, DB_oe;
   logic [ADDR_W-1:0] A_o;
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
   logic              cmd_wait_irq = 1'b0, IRQ_n_i = 1'b1;
`endif

   always #5 phi2 = ~phi2;

   m6502_bus_initiator #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
      .phi2(phi2), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_rs0(cmd_rs0), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .A_o(A_o), .RS0_o(RS0_o),
      .R_W_o(R_W_o), .CS1_o(CS1_o), .DB_o(DB_o), .DB_oe(DB_oe),
`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
      .cmd_wait_irq(cmd_wait_irq), .IRQ_n_i(IRQ_n_i),
`endif
      .DB_i(DB_i)
   );

   typedef struct {
      logic              we;
      logic              rs0;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        wdata;
   } cmd_t;

   int   checks = 0, errors = 0, cyc = 0, free_at = 0;
   int   db_val [MAXC];
   int   e_cs1 [MAXC], e_a [MAXC], e_rs0 [MAXC], e_rw [MAXC], e_oe [MAXC], e_dbo [MAXC];
   int   e_rv [MAXC], e_rd [MAXC], e_busy [MAXC], occ [MAXC];
   int   cur_rd = 0;
   cmd_t script [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < MAXC; i++) begin
         e_cs1[i] = 0; e_a[i] = 0; e_rs0[i] = 0; e_rw[i] = 1; e_oe[i] = 0; e_dbo[i] = 0;
         e_rv[i] = 0; e_rd[i] = 0; e_busy[i] = 0; occ[i] = 0;
      end
      free_at = 0;
      cur_rd  = 0;
   endtask

   // Command accepted at edge e: waits in the queue, occupies the bus once, then
   // holds the initiator until its read data has been returned.
   task automatic model_push(input cmd_t c, input int e);
      int n, dur;
      n   = (e + 1 > free_at) ? e + 1 : free_at;
      dur = c.we ? 1 : LAT;
      free_at = n + dur;
      e_cs1[n] = 1; e_a[n] = int'(c.addr); e_rs0[n] = int'(c.rs0); e_rw[n] = c.we ? 0 : 1;
      e_oe[n] = int'(c.we); e_dbo[n] = c.we ? int'(c.wdata) : 0;
      if (!c.we) begin
         e_rv[n + LAT] = 1;
         e_rd[n + LAT] = db_val[n + LAT - 1];
      end
      for (int i = e; i < n; i++) occ[i]++;
      for (int i = e; i < n + dur; i++) e_busy[i] = 1;
   endtask

   task automatic check_cycle(input int c);
      if (e_rv[c] != 0) cur_rd = e_rd[c];
      chk("cs1", CS1_o, e_cs1[c]);
      chk("addr", A_o, e_a[c]);
      chk("rs0", RS0_o, e_rs0[c]);
      chk("r_w", R_W_o, e_rw[c]);
      chk("db_oe", DB_oe, e_oe[c]);
      chk("db_o", DB_o, e_dbo[c]);
      chk("rsp_valid", rsp_valid, e_rv[c]);
      chk("rsp_rdata", rsp_rdata, cur_rd);
      chk("busy", busy, e_busy[c]);
      chk("cmd_ready", cmd_ready, (occ[c] < DEPTH) ? 1 : 0);
   endtask

   task automatic drive(input int c, input bit rnd);
      cmd_t cm;
      bit   offer;
      cm.we    = 1'($urandom_range(0, 1));
      cm.rs0   = 1'($urandom_range(0, 1));
      cm.addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      cm.wdata = 8'($urandom_range(0, 255));
      if (rnd) begin
         offer = ($urandom_range(0, 99) < 60) && (c + 40 < MAXC);
      end else begin
         offer = (script.size() > 0);
         if (offer) cm = script[0];
      end
      cmd_valid = offer;
      cmd_we    = cm.we;
      cmd_rs0   = cm.rs0;
      cmd_addr  = cm.addr;
      cmd_wdata = cm.wdata;
      if (offer && occ[c] < DEPTH) begin
         model_push(cm, c + 1);
         if (!rnd) void'(script.pop_front());
      end
   endtask

   task automatic phase_reset();
      @(negedge phi2);
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      #1;
      chk("rst_addr", A_o, 0);
      chk("rst_rs0", RS0_o, 0);
      chk("rst_r_w", R_W_o, 1);
      chk("rst_cs1", CS1_o, 0);
      chk("rst_db_o", DB_o, 0);
      chk("rst_db_oe", DB_oe, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      @(negedge phi2);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic run(input int n, input bit rnd);
      for (int c = 0; c < n; c++) begin
         @(posedge phi2);
         #1;
         cyc  = c;
         DB_i = 8'(db_val[c]);
         check_cycle(c);
         drive(c, rnd);
      end
   endtask

   function automatic cmd_t mk(input bit we, input bit rs0, input int addr, input int wd);
      cmd_t c;
      c.we = we; c.rs0 = rs0; c.addr = ADDR_W'(addr); c.wdata = 8'(wd);
      return c;
   endfunction

   initial begin
      bit seen;
      for (int i = 0; i < MAXC; i++) db_val[i] = int'($urandom_range(0, 255));

      // Reset and idle bus with no commands
      phase_reset();
      run(8, 0);

      // Single write
      phase_reset();
      script.push_back(mk(1, 1, 'h3F5, 'hA5));
      run(6, 0);

      // Single read: issue in cycle 2, data sampled in cycle 1+LAT
      phase_reset();
      db_val[LAT + 1] = 'h3C;
      script.push_back(mk(0, 0, 'h07F, 0));
      run(8, 0);

      // Back-to-back writes, then a burst of reads that fills the queue
      phase_reset();
      for (int i = 0; i < 5; i++) script.push_back(mk(1, i[0], 'h100 + i, 'h11 * i));
      run(12, 0);
      phase_reset();
      for (int i = 0; i < 7; i++) script.push_back(mk(0, i[0], 'h200 + i, 0));
      run(24, 0);

      // Random traffic
      phase_reset();
      run(300, 1);
      cmd_valid = 1'b0;

      // Reset while a read is in flight and a second one is queued
      phase_reset();
      script.push_back(mk(0, 1, 'h155, 0));
      script.push_back(mk(0, 0, 'h2AA, 0));
      run(4, 0);
      cmd_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_cs1", CS1_o, 0);
      chk("t5_r_w", R_W_o, 1);
      chk("t5_addr", A_o, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ready", cmd_ready, 1);
      @(negedge phi2);
      rst_n = 1'b1;
      script.delete();
      for (int i = 0; i < 8; i++) begin
         @(posedge phi2);
         #1;
         chk("t5_rsp_valid", rsp_valid, 0);
         chk("t5_post_cs1", CS1_o, 0);
         chk("t5_post_busy", busy, 0);
      end

`ifdef M6502_BUS_INIT_IRQ_WAIT_EN
      phase_reset();
      IRQ_n_i = 1'b1;
      @(posedge phi2); #1;
      cmd_valid = 1'b1; cmd_wait_irq = 1'b1; cmd_we = 1'b1;
      @(posedge phi2); #1;
      cmd_wait_irq = 1'b0; cmd_we = 1'b0; cmd_addr = 'h001;
      @(posedge phi2); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge phi2); #1;
         chk("t6_idle_cs1", CS1_o, 0);
         chk("t6_idle_rv", rsp_valid, 0);
      end
      IRQ_n_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(posedge phi2); #1;
         seen = rsp_valid;
      end
      chk("t6_rsp_seen", seen, 1);
      chk("t6_rdata", rsp_rdata, 'h80);
      seen = CS1_o;
      for (int i = 0; i < 3 && !seen; i++) begin
         @(posedge phi2); #1;
         seen = CS1_o;
      end
      chk("t6_read_issued", seen, 1);
      chk("t6_read_addr", A_o, 'h001);
      chk("t6_read_rw", R_W_o, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
